// File: rtl/pico_top.sv
`default_nettype none
// ============================================================================
// Module   : pico_top
// Brief    : Fixed-program I/O sequencer. Each 8-clock loop runs INPUT,
//            COMPUTE (A+1), OUTPUT and OUTPUTK slots. Defining PICO_TOP_IRQ_EN
//            adds a free-running timer interrupt, serviced at loop boundaries.
// Revision : 1.0 - initial release
// ============================================================================
module pico_top (
    input  logic       clk,
    input  logic       cpu_reset,
    input  logic [7:0] in_port,
    output logic       write_strobe,
    output logic       read_strobe,
    output logic [7:0] out_port,
    output logic [7:0] port_id,
    output logic       k_write_strobe,
    output logic       interrupt_ack
);

    localparam logic [3:0] ST_IDLE  = 4'd0;
    localparam logic [3:0] ST_I0_0  = 4'd1;
    localparam logic [3:0] ST_I0_1  = 4'd2;
    localparam logic [3:0] ST_I1_0  = 4'd3;
    localparam logic [3:0] ST_I1_1  = 4'd4;
    localparam logic [3:0] ST_I2_0  = 4'd5;
    localparam logic [3:0] ST_I2_1  = 4'd6;
    localparam logic [3:0] ST_I3_0  = 4'd7;
    localparam logic [3:0] ST_I3_1  = 4'd8;
`ifdef PICO_TOP_IRQ_EN
    localparam logic [3:0] ST_IRQ_0 = 4'd9;
    localparam logic [3:0] ST_IRQ_1 = 4'd10;
`endif

    localparam logic [7:0] C_PORT_IN  = 8'h00;
    localparam logic [7:0] C_PORT_OUT = 8'h01;
    localparam logic [7:0] C_PORT_K   = 8'h02;
`ifdef PICO_TOP_IRQ_EN
    localparam logic [7:0] C_PORT_IRQ = 8'hFF;
`endif

    logic [3:0] r_state;
    logic [3:0] w_state_nxt;
    logic [7:0] r_a;
    logic [7:0] r_r;
    logic [7:0] r_c;

`ifdef PICO_TOP_IRQ_EN
    logic [7:0] r_timer;
    logic       r_pending;

    // A wrap in the same cycle as the acknowledge wins, so it is not lost.
    always_ff @(posedge clk or negedge cpu_reset) begin
        if (!cpu_reset) begin
            r_timer   <= 8'h00;
            r_pending <= 1'b0;
        end else begin
            r_timer <= r_timer + 8'd1;
            if (r_timer == 8'hFF) begin
                r_pending <= 1'b1;
            end else if (r_state == ST_IRQ_1) begin
                r_pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge cpu_reset) begin
        if (!cpu_reset) begin
            interrupt_ack <= 1'b0;
        end else begin
            interrupt_ack <= (w_state_nxt == ST_IRQ_1);
        end
    end
`else
    assign interrupt_ack = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  w_state_nxt = ST_I0_0;
            ST_I0_0:  w_state_nxt = ST_I0_1;
            ST_I0_1:  w_state_nxt = ST_I1_0;
            ST_I1_0:  w_state_nxt = ST_I1_1;
            ST_I1_1:  w_state_nxt = ST_I2_0;
            ST_I2_0:  w_state_nxt = ST_I2_1;
            ST_I2_1:  w_state_nxt = ST_I3_0;
            ST_I3_0:  w_state_nxt = ST_I3_1;
            ST_I3_1: begin
                w_state_nxt = ST_I0_0;
`ifdef PICO_TOP_IRQ_EN
                if (r_pending) begin
                    w_state_nxt = ST_IRQ_0;
                end
`endif
            end
`ifdef PICO_TOP_IRQ_EN
            ST_IRQ_0: w_state_nxt = ST_IRQ_1;
            ST_IRQ_1: w_state_nxt = ST_I0_0;
`endif
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every port comes straight off a flop.
    always_ff @(posedge clk or negedge cpu_reset) begin
        if (!cpu_reset) begin
            r_state        <= ST_IDLE;
            r_a            <= 8'h00;
            r_r            <= 8'h00;
            r_c            <= 8'h00;
            read_strobe    <= 1'b0;
            write_strobe   <= 1'b0;
            k_write_strobe <= 1'b0;
            port_id        <= 8'h00;
            out_port       <= 8'h00;
        end else begin
            r_state        <= w_state_nxt;
            read_strobe    <= (w_state_nxt == ST_I0_1);
            write_strobe   <= (w_state_nxt == ST_I2_1);
            k_write_strobe <= (w_state_nxt == ST_I3_1);
            case (w_state_nxt)
                ST_I0_0, ST_I0_1: begin
                    port_id <= C_PORT_IN;
                end
                ST_I2_0, ST_I2_1: begin
                    port_id  <= C_PORT_OUT;
                    out_port <= r_r;
                end
                ST_I3_0, ST_I3_1: begin
                    port_id  <= C_PORT_K;
                    out_port <= r_c;
                end
`ifdef PICO_TOP_IRQ_EN
                ST_IRQ_0, ST_IRQ_1: begin
                    port_id <= C_PORT_IRQ;
                end
`endif
                default: begin
                end
            endcase
            if (r_state == ST_I0_1) begin
                r_a <= in_port;
            end
            if (r_state == ST_I1_0) begin
                r_r <= r_a + 8'd1;
            end
            if (r_state == ST_I3_1) begin
                r_c <= r_c + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pico_top.sv
`default_nettype none
// ============================================================================
// Module   : tb_pico_top
// Brief    : Self-checking bench for pico_top against a cycle-level loop model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pico_top;

`ifdef PICO_TOP_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic       clk;
    logic       cpu_reset;
    logic [7:0] in_port;
    logic       write_strobe;
    logic       read_strobe;
    logic [7:0] out_port;
    logic [7:0] port_id;
    logic       k_write_strobe;
    logic       interrupt_ack;

    pico_top dut (
        .clk            (clk),
        .cpu_reset      (cpu_reset),
        .in_port        (in_port),
        .write_strobe   (write_strobe),
        .read_strobe    (read_strobe),
        .out_port       (out_port),
        .port_id        (port_id),
        .k_write_strobe (k_write_strobe),
        .interrupt_ack  (interrupt_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Loop model: position within the 8-clock loop plus an optional inserted IRQ slot.
    int         m_phase;
    bit         m_irq;
    int         m_irqc;
    logic [7:0] m_a, m_r, m_c;
    int         m_timer;
    bit         m_pend;
    logic [7:0] e_pid, e_out;
    logic [3:0] prev_strb;
    int         cyc;
    int         ack_cnt;
    bit         rnd_mode;
    logic [7:0] drv;

    task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = -1; m_irq = 0; m_irqc = 0;
        m_a = 8'h00; m_r = 8'h00; m_c = 8'h00;
        m_timer = 0; m_pend = 0;
        e_pid = 8'h00; e_out = 8'h00;
        prev_strb = 4'h0; cyc = 0; ack_cnt = 0;
    endtask

    task automatic model_edge();
        bit pend_old;
        pend_old = m_pend;
        if (!m_irq && m_phase == 1) m_a = in_port;
        if (!m_irq && m_phase == 3) m_r = m_a + 8'd1;
        if (!m_irq && m_phase == 7) m_c = m_c + 8'd1;
        if (m_irq && m_irqc == 1) m_pend = 0;
        if (IRQ_EN && m_timer == 255) m_pend = 1;
        m_timer = (m_timer + 1) % 256;
        if (m_phase < 0) begin
            m_phase = 0;
        end else if (m_irq) begin
            if (m_irqc == 1) begin m_irq = 0; m_phase = 0; end
            else m_irqc = 1;
        end else if (m_phase == 7) begin
            if (pend_old) begin m_irq = 1; m_irqc = 0; end
            else m_phase = 0;
        end else begin
            m_phase++;
        end
        if (m_irq) begin
            e_pid = 8'hFF;
        end else begin
            case (m_phase / 2)
                0: e_pid = 8'h00;
                2: begin e_pid = 8'h01; e_out = m_r; end
                3: begin e_pid = 8'h02; e_out = m_c; end
                default: ;
            endcase
        end
    endtask

    // One clock: advance the model at the edge, compare on the falling edge, then drive in_port.
    task automatic run(input int n);
        logic [3:0] strb, exp_strb;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            cyc++;
            @(negedge clk);
            strb = {read_strobe, write_strobe, k_write_strobe, interrupt_ack};
            exp_strb = {!m_irq && m_phase == 1, !m_irq && m_phase == 5,
                        !m_irq && m_phase == 7, m_irq && m_irqc == 1};
            chk($sformatf("cycle%0d", cyc), {strb, port_id, out_port}, {exp_strb, e_pid, e_out});
            n_checks++;
            assert ($countones(strb) <= 1) else begin
                n_err++;
                $error("FAIL strobe_excl observed=%b expected=at-most-one", strb);
            end
            chk($sformatf("strobe_width%0d", cyc), {16'h0, strb & prev_strb}, 20'h0);
            prev_strb = strb;
            if (interrupt_ack) ack_cnt++;
            in_port = rnd_mode ? 8'($urandom) : drv;
        end
    endtask

    initial begin
        bit reached;
        cpu_reset = 1'b0;
        rnd_mode  = 1'b0;
        drv       = 8'hF3;
        in_port   = 8'hF3;
        model_reset();

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("reset_hold", {read_strobe, write_strobe, k_write_strobe, interrupt_ack,
                               port_id, out_port}, 20'h0);
        end

        cpu_reset = 1'b1;
        run(2);
        chk("c2_read", {11'h0, read_strobe, port_id}, {11'h0, 1'b1, 8'h00});
        run(4);
        chk("c6_write", {3'h0, write_strobe, port_id, out_port}, {3'h0, 1'b1, 8'h01, 8'hF4});
        run(2);
        chk("c8_kwrite", {3'h0, k_write_strobe, port_id, out_port}, {3'h0, 1'b1, 8'h02, 8'h00});

        drv = 8'h60; in_port = drv;
        run(6);
        chk("c14_write", {3'h0, write_strobe, port_id, out_port}, {3'h0, 1'b1, 8'h01, 8'h61});
        run(2);
        chk("c16_kwrite", {3'h0, k_write_strobe, port_id, out_port}, {3'h0, 1'b1, 8'h02, 8'h01});

        drv = 8'hFF; in_port = drv;
        run(6);
        chk("c22_wrap", {3'h0, write_strobe, port_id, out_port}, {3'h0, 1'b1, 8'h01, 8'h00});
        run(2);
        chk("c24_kwrite", {3'h0, k_write_strobe, port_id, out_port}, {3'h0, 1'b1, 8'h02, 8'h02});

        rnd_mode = 1'b1;
        in_port  = 8'($urandom);
        run(300 - cyc);
        chk("ack_count_300", {12'h0, 8'(ack_cnt)}, {12'h0, (IRQ_EN ? 8'd1 : 8'd0)});

        // Land on the first cycle of the OUTPUT slot, then reset asynchronously mid-slot.
        reached = 0;
        for (int i = 0; i < 20 && !reached; i++) begin
            run(1);
            reached = (m_phase == 4) && !m_irq;
        end
        if (!reached) begin
            n_checks++;
            n_err++;
            $error("FAIL reach_c5 observed=timeout expected=phase4");
        end
        #2 cpu_reset = 1'b0;
        #1;
        chk("reset_immediate", {read_strobe, write_strobe, k_write_strobe, interrupt_ack,
                                port_id, out_port}, 20'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_mid_hold", {read_strobe, write_strobe, k_write_strobe, interrupt_ack,
                                   port_id, out_port}, 20'h0);
        end
        model_reset();
        cpu_reset = 1'b1;
        run(2);
        chk("restart_read", {11'h0, read_strobe, port_id}, {11'h0, 1'b1, 8'h00});
        run(6);
        chk("restart_kwrite", {3'h0, k_write_strobe, port_id, out_port}, {3'h0, 1'b1, 8'h02, 8'h00});
        run(16);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/pico_top.md
PICO_TOP -- requirements
Module: pico_top

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 cpu_reset  input  1  asynchronous active-low reset; 0 = held in reset.
REQ-004 in_port  input  8  input data bus, sampled during read cycles.
REQ-005 write_strobe  output  1  one-cycle pulse; out_port/port_id valid for an OUTPUT.
REQ-006 read_strobe  output  1  one-cycle pulse; in_port sampled at end of this cycle.
REQ-007 out_port  output  8  output data bus.
REQ-008 port_id  output  8  port address for the current I/O operation.
REQ-009 k_write_strobe  output  1  one-cycle pulse; out_port carries a constant-class (OUTPUTK) value.
REQ-010 interrupt_ack  output  1  one-cycle pulse acknowledging an internal interrupt.

Function
REQ-011 The block SHALL run a fixed 4-slot sequence (I0..I3), 2 clocks per slot, 8 clocks per loop, repeating forever.
REQ-012 I0 INPUT: port_id=0x00 both cycles; read_strobe=1 in 2nd cycle only; register A <= in_port at the rising edge ending that cycle.
REQ-013 I1 COMPUTE: R <= A + 1, 8-bit, modulo 256 (0xFF -> 0x00); no strobes; port_id and out_port hold previous values.
REQ-014 I2 OUTPUT: port_id=0x01, out_port=R both cycles; write_strobe=1 in 2nd cycle only.
REQ-015 I3 OUTPUTK: port_id=0x02, out_port=loop counter C both cycles; k_write_strobe=1 in 2nd cycle only; C <= C+1 (mod 256) at the edge ending that cycle.
REQ-016 At most one of read_strobe, write_strobe, k_write_strobe, interrupt_ack SHALL be high in any cycle.
REQ-017 All outputs SHALL be registered (no combinational path from in_port to any output).
REQ-018 After reset release, the first slot executed SHALL be I0, starting on the first rising edge with cpu_reset=1.
REQ-019 in_port changes outside the read_strobe cycle SHALL have no effect on outputs.

Reset
REQ-020 cpu_reset=0 SHALL immediately force all outputs to 0 and clear A, R, C, slot/phase state and (when compiled) the timer and pending flag.
REQ-021 Reset asserted mid-slot SHALL abort the slot; no partial strobe SHALL occur; sequencing restarts at I0 after release.

Configuration
REQ-022 Macro PICO_TOP_IRQ_EN SHALL compile in an internal interrupt source.
REQ-023 With PICO_TOP_IRQ_EN: an 8-bit free-running timer counts every clock out of reset; on reaching 0xFF it sets a pending flag and wraps to 0x00.
REQ-024 With PICO_TOP_IRQ_EN: if pending at a loop boundary (before I0), a 2-cycle IRQ slot SHALL run: port_id=0xFF, out_port unchanged, interrupt_ack=1 in 2nd cycle, pending cleared at that edge; then I0 proceeds. Pending set during a loop waits for the next boundary; a second timer wrap while pending is merged.
REQ-025 Without PICO_TOP_IRQ_EN: no timer, interrupt_ack tied to 0, loop is strictly 8 clocks.

Verification
REQ-026 cpu_reset=0 held, in_port=0xF3 -> all outputs 0 for the whole reset period.
REQ-027 Release reset, in_port=0xF3 -> read_strobe in cycle 2 with port_id=0x00; write_strobe in cycle 6 with port_id=0x01, out_port=0xF4; k_write_strobe in cycle 8 with port_id=0x02, out_port=0x00.
REQ-028 Change in_port to 0x60 -> next loop write_strobe with out_port=0x61; k_write_strobe value increments by 1 per loop; in_port=0xFF -> out_port=0x00 (wrap).
REQ-029 Assert cpu_reset in cycle 5 of a loop -> outputs 0 at once, no write_strobe; after release sequence restarts at I0 with C=0x00.
REQ-030 With PICO_TOP_IRQ_EN, run 300 clocks -> exactly one interrupt_ack pulse with port_id=0xFF, occurring at a loop boundary, followed by a normal I0; without macro interrupt_ack stays 0.
REQ-031 Every cycle: assert strobe mutual exclusivity and each strobe is exactly one clock wide.
